// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed display scanner with per-frame input snapshot, anode dead time and blinking.
// Define SEG_SCAN_LZB_EN to blank leading zeros in the three most significant slots at snapshot time.
module seg_scan_mux #(
   parameter int SCAN_DIV    = 8192,
   parameter int DEAD_CYCLES = 16,
   parameter int BLINK_DIV   = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] dig0,
   input  logic [4:0] dig1,
   input  logic [4:0] dig2,
   input  logic [4:0] dig3,
   input  logic [3:0] dp_in,
   input  logic [3:0] blank_mask,
   input  logic [3:0] blink_mask,
   output logic [4:0] code,
   output logic [3:0] an,
   output logic       dp,
   output logic       frame
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [4:0] BLANK = 5'd10;

   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_slot;
   logic [FW-1:0]   r_fcnt;
   logic            r_bphase;
   logic [3:0][4:0] r_dig;
   logic [3:0]      r_dp_sh;
   logic [3:0]      r_blank_sh;
   logic [3:0]      r_blink_sh;
   logic [3:0]      r_an;
   logic [4:0]      r_code;
   logic            r_dp;
   logic            r_frame;

   logic [3:0][4:0] w_dig_in;
   logic [3:0][4:0] w_dig_snap;
   logic            w_slot_end;
   logic            w_frame_end;
   logic            w_fcnt_end;
   logic            w_dark;
   logic            w_dead;

   assign w_dig_in[0] = dig0;
   assign w_dig_in[1] = dig1;
   assign w_dig_in[2] = dig2;
   assign w_dig_in[3] = dig3;

   genvar gi;
`ifdef SEG_SCAN_LZB_EN
   // w_lead[gi]: every slot above gi holds 0 or blank, so a zero in gi is a leading zero
   logic [3:1] w_lead;
   assign w_lead[3] = 1'b1;
   generate
      for (gi = 2; gi >= 1; gi--) begin : g_lead
         assign w_lead[gi] = w_lead[gi+1] &&
                             (w_dig_in[gi+1] == 5'd0 || w_dig_in[gi+1] == BLANK);
      end
      for (gi = 3; gi >= 1; gi--) begin : g_lzb
         assign w_dig_snap[gi] = (w_lead[gi] && w_dig_in[gi] == 5'd0) ? BLANK : w_dig_in[gi];
      end
   endgenerate
   assign w_dig_snap[0] = w_dig_in[0];
`else
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pass
         assign w_dig_snap[gi] = w_dig_in[gi];
      end
   endgenerate
`endif

   assign w_slot_end  = (r_cnt == CW'(SCAN_DIV - 1));
   assign w_frame_end = w_slot_end && (r_slot == 2'd3);
   assign w_fcnt_end  = (r_fcnt == FW'(BLINK_DIV - 1));
   assign w_dark      = r_blank_sh[r_slot] | (r_blink_sh[r_slot] & r_bphase);
   assign w_dead      = (r_cnt < CW'(DEAD_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_slot     <= 2'd0;
         r_fcnt     <= '0;
         r_bphase   <= 1'b0;
         r_dig      <= {4{BLANK}};
         r_dp_sh    <= 4'b0000;
         r_blank_sh <= 4'b1111;
         r_blink_sh <= 4'b0000;
         r_an       <= 4'b1111;
         r_code     <= BLANK;
         r_dp       <= 1'b1;
         r_frame    <= 1'b0;
      end else begin
         r_cnt <= w_slot_end ? '0 : r_cnt + CW'(1);
         if (w_slot_end) begin
            r_slot <= r_slot + 2'd1;
         end
         // Inputs are only sampled here so a frame never mixes old and new values
         if (w_frame_end) begin
            r_dig      <= w_dig_snap;
            r_dp_sh    <= dp_in;
            r_blank_sh <= blank_mask;
            r_blink_sh <= blink_mask;
            r_fcnt     <= w_fcnt_end ? '0 : r_fcnt + FW'(1);
            if (w_fcnt_end) begin
               r_bphase <= ~r_bphase;
            end
         end
         r_an    <= (w_dead | w_dark) ? 4'b1111 : ~(4'b0001 << r_slot);
         r_code  <= w_dark ? BLANK : r_dig[r_slot];
         r_dp    <= (w_dead | w_dark) ? 1'b1 : ~r_dp_sh[r_slot];
         r_frame <= w_frame_end;
      end
   end

   assign an    = r_an;
   assign code  = r_code;
   assign dp    = r_dp;
   assign frame = r_frame;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux; expected outputs come from a time-indexed behavioural model.
module tb_seg_scan_mux;

   localparam int SD = 8;
   localparam int DC = 2;
   localparam int BD = 2;
   localparam int FL = 4 * SD;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] dig0, dig1, dig2, dig3;
   logic [3:0] dp_in, blank_mask, blink_mask;
   logic [4:0] code;
   logic [3:0] an;
   logic       dp, frame;

   always #5 clk = ~clk;

   seg_scan_mux #(.SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_DIV(BD)) dut (
      .clk(clk), .reset(reset),
      .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
      .dp_in(dp_in), .blank_mask(blank_mask), .blink_mask(blink_mask),
      .code(code), .an(an), .dp(dp), .frame(frame)
   );

   int checks = 0;
   int fails  = 0;

   // Model: m_t = cycles since reset release; shadows hold the values shown in the current frame
   int         m_t;
   logic [4:0] m_dig [4];
   logic [3:0] m_dp, m_blank, m_blink;
   logic [3:0] e_an;
   logic [4:0] e_code;
   logic       e_dp, e_frame;
   int         o_slot, o_cnt, o_f;

   task automatic tick();
      int slot, cnt, f;
      bit dark;
      logic [4:0] d [4];
      if (reset) begin
         m_t = 0;
         for (int s = 0; s < 4; s++) m_dig[s] = 5'd10;
         m_dp = 4'h0; m_blank = 4'hF; m_blink = 4'h0;
         e_an = 4'hF; e_code = 5'd10; e_dp = 1'b1; e_frame = 1'b0;
         o_slot = -1; o_cnt = -1; o_f = -1;
      end else begin
         slot = (m_t / SD) % 4;
         cnt  = m_t % SD;
         f    = m_t / FL;
         dark = m_blank[slot] || (m_blink[slot] && ((f / BD) % 2 == 1));
         e_an    = (cnt < DC || dark) ? 4'hF : ~(4'b0001 << slot);
         e_code  = dark ? 5'd10 : m_dig[slot];
         e_dp    = (cnt < DC || dark) ? 1'b1 : ~m_dp[slot];
         e_frame = (m_t % FL == FL - 1);
         o_slot = slot; o_cnt = cnt; o_f = f;
         if (e_frame) begin
            d[0] = dig0; d[1] = dig1; d[2] = dig2; d[3] = dig3;
            for (int s = 0; s < 4; s++) m_dig[s] = d[s];
`ifdef SEG_SCAN_LZB_EN
            for (int s = 3; s >= 1; s--) begin
               if (d[s] == 5'd0) m_dig[s] = 5'd10;
               else if (d[s] != 5'd10) break;
            end
`endif
            m_dp = dp_in; m_blank = blank_mask; m_blink = blink_mask;
         end
         m_t++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      dig0 = 5'($urandom); dig1 = 5'($urandom); dig2 = 5'($urandom); dig3 = 5'($urandom);
      dp_in = 4'($urandom); blank_mask = 4'($urandom); blink_mask = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (an !== 4'hF || code !== 5'd10 || dp !== 1'b1 || frame !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold cyc=%0d got an=%b code=%0d dp=%b frame=%b want 1111/10/1/0",
                     i, an, code, dp, frame);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (an !== 4'hF || code !== 5'd10 || dp !== 1'b1 || frame !== (i == 31)) begin
            fails++;
            $display("FAIL reset_dark cyc=%0d got an=%b code=%0d dp=%b frame=%b want 1111/10/1/%b",
                     i, an, code, dp, frame, (i == 31));
         end
      end
      $display("test_reset done checks=%0d", checks);
   endtask

   task automatic test_scan_order();
      logic [4:0] sc [4];
      sc = '{5'd5, 5'd11, 5'd12, 5'd20};
      dig3 = 5'd20; dig2 = 5'd12; dig1 = 5'd11; dig0 = 5'd5;
      blank_mask = 4'h0; blink_mask = 4'h0; dp_in = 4'b0010;
      for (int i = 0; i < 2 * FL; i++) begin
         tick();
         checks++;
         if ({an, code, dp, frame} !== {e_an, e_code, e_dp, e_frame}) begin
            fails++;
            $display("FAIL scan t=%0d got an=%b code=%0d dp=%b frame=%b want an=%b code=%0d dp=%b frame=%b",
                     m_t - 1, an, code, dp, frame, e_an, e_code, e_dp, e_frame);
         end
         if (i >= FL && o_cnt == 4) begin
            checks++;
            if (code !== sc[o_slot] || an !== ~(4'b0001 << o_slot) || dp !== (o_slot != 1)) begin
               fails++;
               $display("FAIL scan_slot slot=%0d got code=%0d an=%b dp=%b want code=%0d an=%b dp=%b",
                        o_slot, code, an, dp, sc[o_slot], ~(4'b0001 << o_slot), (o_slot != 1));
            end
         end
      end
      $display("test_scan_order done checks=%0d", checks);
   endtask

   task automatic test_snapshot();
      bit changed = 0;
      int chg_f = -10;
      for (int i = 0; i < 3 * FL; i++) begin
         if (!changed && (m_t / SD) % 4 == 2 && m_t % SD == 3) begin
            dig0 = 5'd9; dig2 = 5'd13; changed = 1; chg_f = m_t / FL;
         end
         tick();
         checks++;
         if ({an, code, dp, frame} !== {e_an, e_code, e_dp, e_frame}) begin
            fails++;
            $display("FAIL snapshot t=%0d got an=%b code=%0d dp=%b frame=%b want an=%b code=%0d dp=%b frame=%b",
                     m_t - 1, an, code, dp, frame, e_an, e_code, e_dp, e_frame);
         end
         if (changed && o_f == chg_f && o_slot == 2 && o_cnt >= 4) begin
            checks++;
            if (code !== 5'd12) begin
               fails++;
               $display("FAIL no_tear cnt=%0d got code=%0d want 12", o_cnt, code);
            end
         end
         if (changed && o_f == chg_f + 1 && o_slot == 0 && o_cnt == 4) begin
            checks++;
            if (code !== 5'd9) begin
               fails++;
               $display("FAIL snap_new got code=%0d want 9", code);
            end
         end
      end
      $display("test_snapshot done checks=%0d", checks);
   endtask

   task automatic test_blink();
      int start_f, lit = 0, drk = 0;
      blink_mask = 4'b0001; dig0 = 5'd7; blank_mask = 4'h0;
      start_f = m_t / FL;
      for (int i = 0; i < 9 * FL; i++) begin
         tick();
         checks++;
         if ({an, code, dp, frame} !== {e_an, e_code, e_dp, e_frame}) begin
            fails++;
            $display("FAIL blink t=%0d got an=%b code=%0d dp=%b frame=%b want an=%b code=%0d dp=%b frame=%b",
                     m_t - 1, an, code, dp, frame, e_an, e_code, e_dp, e_frame);
         end
         if (o_f > start_f && o_slot == 0 && o_cnt == 4) begin
            if (code == 5'd7 && an == 4'b1110) lit++;
            if (code == 5'd10 && an == 4'b1111) drk++;
         end
      end
      checks++;
      if (lit != 4 || drk != 4) begin
         fails++;
         $display("FAIL blink_ratio got lit=%0d dark=%0d want 4/4", lit, drk);
      end
      $display("test_blink done checks=%0d", checks);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6 * FL; i++) begin
         if ($urandom_range(7) == 0) begin
            dig0 = 5'($urandom); dig1 = 5'($urandom); dig2 = 5'($urandom); dig3 = 5'($urandom);
            dp_in = 4'($urandom); blank_mask = 4'($urandom); blink_mask = 4'($urandom);
         end
         tick();
         checks++;
         if ({an, code, dp, frame} !== {e_an, e_code, e_dp, e_frame}) begin
            fails++;
            $display("FAIL random t=%0d got an=%b code=%0d dp=%b frame=%b want an=%b code=%0d dp=%b frame=%b",
                     m_t - 1, an, code, dp, frame, e_an, e_code, e_dp, e_frame);
         end
      end
      $display("test_random done checks=%0d", checks);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      bit seen = 0;
      for (int i = 0; i < 2 * FL && m_t % FL != 2 * SD + 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (an !== 4'hF || code !== 5'd10 || dp !== 1'b1 || frame !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid got an=%b code=%0d dp=%b frame=%b want 1111/10/1/0", an, code, dp, frame);
      end
      while (!seen && n < 40) begin
         tick();
         n++;
         if (frame === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || n != 32) begin
         fails++;
         $display("FAIL reset_mid_frame got frame after %0d cycles (seen=%0d) want 32", n, seen);
      end
      $display("test_reset_mid done checks=%0d", checks);
   endtask

   task automatic test_lzb();
      logic [4:0] lz [4];
      int start_f;
`ifdef SEG_SCAN_LZB_EN
      lz = '{5'd0, 5'd4, 5'd10, 5'd10};
`else
      lz = '{5'd0, 5'd4, 5'd0, 5'd0};
`endif
      dig3 = 5'd0; dig2 = 5'd0; dig1 = 5'd4; dig0 = 5'd0;
      blank_mask = 4'h0; blink_mask = 4'h0; dp_in = 4'h0;
      start_f = m_t / FL;
      for (int i = 0; i < 2 * FL; i++) begin
         tick();
         checks++;
         if ({an, code, dp, frame} !== {e_an, e_code, e_dp, e_frame}) begin
            fails++;
            $display("FAIL lzb t=%0d got an=%b code=%0d dp=%b frame=%b want an=%b code=%0d dp=%b frame=%b",
                     m_t - 1, an, code, dp, frame, e_an, e_code, e_dp, e_frame);
         end
         if (o_f == start_f + 1 && o_cnt == 4) begin
            checks++;
            if (code !== lz[o_slot]) begin
               fails++;
               $display("FAIL lzb_code slot=%0d got code=%0d want %0d", o_slot, code, lz[o_slot]);
            end
         end
      end
      $display("test_lzb done checks=%0d", checks);
   endtask

   initial begin
      m_t = 0;
      test_reset();
      test_scan_order();
      test_snapshot();
      test_blink();
      test_random();
      test_reset_mid();
      test_lzb();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
